// File: rtl/scan_chain_pkg.sv
// rtl/scan_chain_pkg.sv - shared types and counter width helper for the scan chain loader
package scan_chain_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SHIFT  = 2'd1,
        UPDATE = 2'd2
    } state_t;

    // Counter width for a count range of n values; never narrower than one bit.
    function automatic int cnt_width(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/shift_tick_gen.sv
// rtl/shift_tick_gen.sv - bit-period divider producing one tick per SHIFT_DIV window
module shift_tick_gen
    import scan_chain_pkg::*;
#(
    parameter int SHIFT_DIV = 1
) (
    input  logic CLK,
    input  logic RST,
    input  logic en,
    output logic tick
);

    localparam int DW = cnt_width(SHIFT_DIV);
    localparam logic [DW-1:0] LAST = DW'(SHIFT_DIV - 1);

    logic [DW-1:0] divcnt;

    // Position within the current bit period; held at zero while disabled so each transfer starts a fresh window.
    always_ff @(posedge CLK) begin
        if (RST || !en) begin
            divcnt <= '0;
        end else if (divcnt == LAST) begin
            divcnt <= '0;
        end else begin
            divcnt <= divcnt + 1'b1;
        end
    end

    assign tick = en && (divcnt == LAST);

endmodule

// File: rtl/scan_chain_ctrl.sv
// rtl/scan_chain_ctrl.sv - loads a config word into a scan chain and captures its previous contents
module scan_chain_ctrl
    import scan_chain_pkg::*;
#(
    parameter int CHAIN_LEN = 8,
    parameter int SHIFT_DIV = 1
) (
    input  logic                 CLK,
    input  logic                 RST,
    input  logic                 cfg_valid,
    output logic                 cfg_ready,
    input  logic [CHAIN_LEN-1:0] cfg_data,
    output logic                 SO,
    output logic                 SE,
    input  logic                 SI,
    output logic                 UPD,
    output logic                 rb_valid,
    output logic [CHAIN_LEN-1:0] rb_data,
    output logic                 busy
);

    localparam int BW = cnt_width(CHAIN_LEN + 1);
    localparam logic [BW-1:0] LAST_BIT = BW'(CHAIN_LEN - 1);

    state_t               state;
    logic [CHAIN_LEN-1:0] sreg;
    logic [CHAIN_LEN-1:0] rbreg;
    logic [CHAIN_LEN-1:0] rb_next;
    logic [BW-1:0]        bitcnt;
    logic                 tick;

    shift_tick_gen #(
        .SHIFT_DIV (SHIFT_DIV)
    ) u_tick (
        .CLK  (CLK),
        .RST  (RST),
        .en   (state == SHIFT),
        .tick (tick)
    );

    // The tail bit seen before each shift edge is the old content of the flop that is leaving the chain.
    assign rb_next = {rbreg[CHAIN_LEN-2:0], SI};

    // Sequencer: accept a word, shift it out MSB-first one bit per period, then strobe the update.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state   <= IDLE;
            sreg    <= '0;
            rbreg   <= '0;
            bitcnt  <= '0;
            rb_data <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (cfg_valid && cfg_ready) begin
                        sreg   <= cfg_data;
                        bitcnt <= '0;
                        state  <= SHIFT;
                    end
                end
                SHIFT: begin
                    if (tick) begin
                        sreg   <= sreg << 1;
                        rbreg  <= rb_next;
                        bitcnt <= bitcnt + 1'b1;
                        if (bitcnt == LAST_BIT) begin
                            rb_data <= rb_next;
                            state   <= UPDATE;
                        end
                    end
                end
                UPDATE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    assign cfg_ready = (state == IDLE) && !RST;
    assign SO        = (state == SHIFT) ? sreg[CHAIN_LEN-1] : 1'b0;
    assign SE        = (state == SHIFT) && tick;
    assign UPD       = (state == UPDATE);
    assign rb_valid  = (state == UPDATE);
    assign busy      = (state != IDLE);

endmodule

// File: tb/tb_scan_chain_ctrl.sv
// tb/tb_scan_chain_ctrl.sv - randomized self-checking bench for scan_chain_ctrl against a DFF chain model
module tb_scan_chain_ctrl;

    localparam int N = 3;

    logic                CLK = 1'b0;
    logic                RST = 1'b1;
    logic [N-1:0]        cfg_valid = '0;
    logic [N-1:0][7:0]   cfg_data = '0;
    wire  [N-1:0]        cfg_ready;
    wire  [N-1:0]        so;
    wire  [N-1:0]        se;
    wire  [N-1:0]        si;
    wire  [N-1:0]        upd;
    wire  [N-1:0]        rb_valid;
    wire  [N-1:0]        busy;
    wire  [N-1:0][7:0]   rbd;
    logic [N-1:0][7:0]   chain = '0;

    int vectors = 0;
    int miscompares = 0;

    always #5 CLK = ~CLK;

    function automatic int len_of(input int i);
        return (i == 2) ? 2 : 8;
    endfunction

    function automatic int div_of(input int i);
        return (i == 1) ? 3 : 1;
    endfunction

    scan_chain_ctrl #(.CHAIN_LEN(8), .SHIFT_DIV(1)) u0 (
        .CLK(CLK), .RST(RST), .cfg_valid(cfg_valid[0]), .cfg_ready(cfg_ready[0]),
        .cfg_data(cfg_data[0]), .SO(so[0]), .SE(se[0]), .SI(si[0]), .UPD(upd[0]),
        .rb_valid(rb_valid[0]), .rb_data(rbd[0]), .busy(busy[0])
    );

    scan_chain_ctrl #(.CHAIN_LEN(8), .SHIFT_DIV(3)) u1 (
        .CLK(CLK), .RST(RST), .cfg_valid(cfg_valid[1]), .cfg_ready(cfg_ready[1]),
        .cfg_data(cfg_data[1]), .SO(so[1]), .SE(se[1]), .SI(si[1]), .UPD(upd[1]),
        .rb_valid(rb_valid[1]), .rb_data(rbd[1]), .busy(busy[1])
    );

    scan_chain_ctrl #(.CHAIN_LEN(2), .SHIFT_DIV(1)) u2 (
        .CLK(CLK), .RST(RST), .cfg_valid(cfg_valid[2]), .cfg_ready(cfg_ready[2]),
        .cfg_data(cfg_data[2][1:0]), .SO(so[2]), .SE(se[2]), .SI(si[2]), .UPD(upd[2]),
        .rb_valid(rb_valid[2]), .rb_data(rbd[2][1:0]), .busy(busy[2])
    );

    assign rbd[2][7:2] = '0;

    // Chain of DFFPOSX1 cells: SE selects the previous Q, otherwise the functional D holds the current value.
    always @(posedge CLK) begin
        for (int i = 0; i < N; i++) begin
            if (se[i]) chain[i] <= {chain[i][6:0], so[i]} & (8'hFF >> (8 - len_of(i)));
        end
    end

    assign si[0] = chain[0][7];
    assign si[1] = chain[1][7];
    assign si[2] = chain[2][1];

    // One complete load on instance i, checked cycle by cycle against the expected protocol timeline.
    task automatic do_load(input int i, input logic [7:0] word_in, input bit hold, input bit b2b);
        int L = len_of(i);
        int D = div_of(i);
        int T = L * D;
        logic [7:0] word;
        logic [7:0] old;
        logic [5:0] got;
        logic [5:0] exp;
        logic       e_so;
        word = word_in & (8'hFF >> (8 - L));
        if (!b2b) @(negedge CLK);
        old = chain[i];
        vectors++;
        if (cfg_ready[i] !== 1'b1) begin
            miscompares++;
            $display("FAIL ready_idle inst=%0d got=%b exp=1", i, cfg_ready[i]);
        end
        cfg_valid[i] = 1'b1;
        cfg_data[i]  = word;
        for (int c = 1; c <= T + 2; c++) begin
            @(negedge CLK);
            e_so = (c <= T) ? word[L - 1 - (c - 1) / D] : 1'b0;
            exp  = {(c <= T) && (c % D == 0), e_so, c == T + 1, c == T + 1, c == T + 2, c <= T + 1};
            got  = {se[i], so[i], upd[i], rb_valid[i], cfg_ready[i], busy[i]};
            vectors++;
            if (got !== exp) begin
                miscompares++;
                $display("FAIL timeline inst=%0d cyc=%0d {SE,SO,UPD,rbv,rdy,busy} got=%b exp=%b", i, c, got, exp);
            end
            if (c >= T + 1) begin
                vectors++;
                if (rbd[i] !== old) begin
                    miscompares++;
                    $display("FAIL rb_data inst=%0d cyc=%0d got=%h exp=%h", i, c, rbd[i], old);
                end
            end
            if (c == T + 2) begin
                vectors++;
                if (chain[i] !== word) begin
                    miscompares++;
                    $display("FAIL chain inst=%0d got=%h exp=%h", i, chain[i], word);
                end
            end
            if (!hold && c == 1) begin
                cfg_valid[i] = 1'b0;
                cfg_data[i]  = 8'($urandom);
            end
            if (hold && c <= T) cfg_data[i] = 8'($urandom);
            if (hold && c == T + 1) cfg_valid[i] = 1'b0;
        end
    endtask

    task automatic test_reset;
        repeat (3) @(posedge CLK);
        @(negedge CLK);
        vectors++;
        if ({so, se, upd, rb_valid, busy, cfg_ready} !== '0 || rbd !== '0) begin
            miscompares++;
            $display("FAIL reset_outputs got=%b rb=%h exp=0", {so, se, upd, rb_valid, busy, cfg_ready}, rbd);
        end
        RST = 1'b0;
        @(negedge CLK);
        vectors++;
        if (cfg_ready !== 3'b111 || busy !== 3'b000) begin
            miscompares++;
            $display("FAIL ready_after_reset got=%b/%b exp=111/000", cfg_ready, busy);
        end
    endtask

    task automatic test_load_basic;
        do_load(0, 8'hA5, 1'b0, 1'b0);
    endtask

    task automatic test_back_to_back;
        do_load(0, 8'h3C, 1'b0, 1'b1);
    endtask

    task automatic test_slow_shift;
        do_load(1, 8'hFF, 1'b0, 1'b0);
        do_load(1, 8'($urandom), 1'b0, 1'b1);
    endtask

    task automatic test_valid_held;
        do_load(0, 8'($urandom), 1'b1, 1'b0);
        do_load(1, 8'($urandom), 1'b1, 1'b0);
    endtask

    task automatic test_reset_mid_shift;
        @(negedge CLK);
        cfg_valid[0] = 1'b1;
        cfg_data[0]  = 8'($urandom);
        @(negedge CLK);
        cfg_valid[0] = 1'b0;
        repeat (3) @(negedge CLK);
        RST = 1'b1;
        @(negedge CLK);
        vectors++;
        if ({se[0], upd[0], busy[0], cfg_ready[0]} !== 4'b0000) begin
            miscompares++;
            $display("FAIL mid_reset {SE,UPD,busy,rdy} got=%b exp=0000", {se[0], upd[0], busy[0], cfg_ready[0]});
        end
        RST = 1'b0;
        for (int c = 0; c < 12; c++) begin
            @(negedge CLK);
            vectors++;
            if ({rb_valid[0], upd[0], se[0], cfg_ready[0]} !== 4'b0001) begin
                miscompares++;
                $display("FAIL post_reset cyc=%0d {rbv,UPD,SE,rdy} got=%b exp=0001", c, {rb_valid[0], upd[0], se[0], cfg_ready[0]});
            end
        end
    endtask

    task automatic test_short_chain;
        do_load(2, 8'h01, 1'b0, 1'b0);
        do_load(2, 8'h02, 1'b0, 1'b1);
        do_load(2, 8'($urandom), 1'b1, 1'b0);
    endtask

    task automatic test_random;
        for (int k = 0; k < 10; k++) begin
            repeat ($urandom_range(0, 3)) @(negedge CLK);
            do_load($urandom_range(0, 2), 8'($urandom), 1'($urandom_range(0, 1)), 1'b0);
        end
    endtask

    initial begin
        test_reset;
        test_load_basic;
        test_back_to_back;
        test_slow_shift;
        test_valid_held;
        test_reset_mid_shift;
        test_short_chain;
        test_random;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #500000;
        miscompares++;
        $display("FAIL watchdog time limit reached");
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
